decoder_pipe_nto2n: RTL
=======================

Name: decoder_pipe_nto2n

Overview:
Parametrised, handshaked successor to the fixed 5-to-32 decoder. It converts an IN_W-bit select into a 2^IN_W-bit word, either one-hot or thermometer. Results pass through a registered 2-entry output buffer with valid/ready flow control. It sits between the instruction-decode stage and register-file write-enable / shifter-mask consumers that may stall.

Parameters:
IN_W, 5, select width; output width OUT_W = 2**IN_W (derived localparam, not overridable); legal range 1..6.
MODE_THERM_ALLOWED, 1, 1 = thermometer mode honoured; 0 = in_mode ignored, always one-hot.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  upstream request valid.
in_ready  output  1  block can accept a request this cycle.
in_sel  input  IN_W  select index.
in_mode  input  1  0 = one-hot, 1 = thermometer.
in_en  input  1  0 = decode to all-zeros (request still consumed).
out_valid  output  1  out_dec/out_sel hold a valid result.
out_ready  input  1  downstream accepts the result.
out_dec  output  OUT_W  decoded word.
out_sel  output  IN_W  select that produced out_dec (pass-through tag).

Behaviour:
- Decode (combinational, on the input side):
  - in_en=0 -> all zeros.
  - one-hot -> bit in_sel set only.
  - thermometer -> bits [in_sel:0] set; in_sel=0 gives 1, in_sel=OUT_W-1 gives all ones.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Buffer: 2 entries, head/tail registers; occupancy FSM EMPTY / ONE / TWO.
  - EMPTY: accept -> ONE.
  - ONE: accept & !pop -> TWO; pop & !accept -> EMPTY; accept & pop -> ONE, new entry becomes head the next cycle.
  - TWO: pop -> ONE (tail moves to head); no accept possible.
- in_ready = (state != TWO). It is registered from the FSM, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_dec/out_sel are driven from the head register only (no combinational input-to-output path).
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput: 1 per cycle while out_ready=1.
- Hold: while out_valid=1 & out_ready=0, out_dec/out_sel remain stable.
- When out_valid=0, out_dec and out_sel read 0.
- Reset: state=EMPTY; in_ready=1, out_valid=0, out_dec=0, out_sel=0 on the cycle after rst is sampled high. Buffered entries are discarded. rst dominates a simultaneous accept/pop.
- in_sel is always in range by construction (OUT_W = 2**IN_W), so no out-of-range case exists.

Optional Feature:
- Macro: DECODER_ZERO_MASK_EN.
- Defined: bit 0 of out_dec is forced to 0 for every decode in both modes (register zero is never write-enabled). in_sel=0 in one-hot mode therefore yields all zeros but is still transferred with out_sel=0.
- Undefined: no masking; bit 0 follows the decode rules above.

Decomposition:
- Package decoder_pkg holds:
  - mode constants DEC_MODE_ONEHOT=1'b0 and DEC_MODE_THERM=1'b1;
  - the occupancy-state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
- Sub-module decoder_core: purely combinational, parametrised on IN_W, with inputs sel, mode, en and output dec. It holds the decode and zero-mask logic, so the handshake/buffer logic in the top stays separate and the core can be unit-tested on its own.

Test Plan:
- Reset release, IN_W=5; in_sel=5'd3, mode=0, en=1, valid=1, out_ready=1 -> next cycle out_valid=1, out_dec=32'h0000_0008, out_sel=3.
- Thermometer: in_sel=5'd4, mode=1 -> out_dec=32'h0000_001F; in_sel=5'd31 -> 32'hFFFF_FFFF; with MODE_THERM_ALLOWED=0 the in_sel=4 request gives 32'h0000_0010.
- Backpressure: out_ready=0; push sel 1, 2, 3 back-to-back -> in_ready drops after the 2nd accept; sel 3 is held upstream. Raise out_ready -> outputs 2, 4, then 8 in order, no loss or duplicate.
- Simultaneous accept+pop in ONE: steady stream sel 0..31 with out_ready=1 -> in_ready stays 1 and 32 consecutive one-hot words appear.
- in_en=0 with in_sel=7 -> out_dec=0, out_sel=7, handshake completes. With DECODER_ZERO_MASK_EN: sel=0 mode=0 -> 0; sel=2 mode=1 -> 32'h0000_0006.
- Reset mid-operation: buffer in TWO, assert rst for 1 cycle -> out_valid=0, out_dec=0, in_ready=1 next cycle; buffered entries never appear.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants for the handshaked N-to-2^N decoder: the decode modes
// and the encoding of the output buffer's occupancy state.
package decoder_pkg;

  localparam logic DEC_MODE_ONEHOT = 1'b0;
  localparam logic DEC_MODE_THERM  = 1'b1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/decoder_core.sv
// Combinational select decoder: one-hot or thermometer, all-zeros when disabled.
// DECODER_ZERO_MASK_EN forces bit 0 low so register zero is never enabled.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int IN_W = 5
) (
  input  logic [IN_W-1:0]        sel,
  input  logic                   mode,
  input  logic                   en,
  output logic [(1<<IN_W)-1:0]   dec
);

  localparam int OUT_W = 1 << IN_W;

  always_comb begin
    dec = '0;
    if (en) begin
      if (mode == DEC_MODE_THERM) begin
        for (int i = 0; i < OUT_W; i++) begin
          dec[i] = (i <= int'(sel));
        end
      end else begin
        dec[sel] = 1'b1;
      end
    end
`ifdef DECODER_ZERO_MASK_EN
    dec[0] = 1'b0;
`else
    dec = dec;
`endif
  end

endmodule

// File: rtl/decoder_pipe_nto2n.sv
// Decoder with a registered 2-entry valid/ready output buffer; 1-cycle latency,
// full throughput. Optional bit-0 masking via DECODER_ZERO_MASK_EN.
module decoder_pipe_nto2n
  import decoder_pkg::*;
#(
  parameter int IN_W               = 5,
  parameter bit MODE_THERM_ALLOWED = 1'b1,
  localparam int OUT_W             = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sel,
  input  logic             in_mode,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_dec,
  output logic [IN_W-1:0]  out_sel
);

  occ_state_e       state_q;
  logic             in_ready_q, out_valid_q;
  logic [OUT_W-1:0] head_dec_q, tail_dec_q;
  logic [IN_W-1:0]  head_sel_q, tail_sel_q;
  logic [OUT_W-1:0] dec_d;
  logic             mode_eff;
  logic             accept, pop;

  assign mode_eff = MODE_THERM_ALLOWED ? in_mode : DEC_MODE_ONEHOT;

  decoder_core #(.IN_W(IN_W)) u_core (
    .sel  (in_sel),
    .mode (mode_eff),
    .en   (in_en),
    .dec  (dec_d)
  );

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_dec_q  <= '0;
      head_sel_q  <= '0;
      tail_dec_q  <= '0;
      tail_sel_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          head_dec_q  <= dec_d;
          head_sel_q  <= in_sel;
          state_q     <= ONE;
          out_valid_q <= 1'b1;
        end
        ONE: begin
          if (accept && pop) begin
            head_dec_q <= dec_d;
            head_sel_q <= in_sel;
          end else if (accept) begin
            tail_dec_q <= dec_d;
            tail_sel_q <= in_sel;
            state_q    <= TWO;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: if (pop) begin
          // Tail slides into head; the freed slot reopens the input next cycle.
          head_dec_q <= tail_dec_q;
          head_sel_q <= tail_sel_q;
          state_q    <= ONE;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_dec   = out_valid_q ? head_dec_q : '0;
  assign out_sel   = out_valid_q ? head_sel_q : '0;

endmodule
